// File: rtl/jt900h_fetch_pkg.sv
// Shared definitions for the jt900h prefetch unit: FSM encodings and fetch threshold.
package jt900h_fetch_pkg;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_WAIT = 2'd1,
    FS_DROP = 2'd2
  } fstate_t;

  // Free bytes that must be available before a word fetch is issued,
  // so an acknowledged word always fits in the queue.
  localparam int FETCH_SPACE = 2;

endpackage

// File: rtl/jt900h_fetch_queue.sv
// Byte shift queue: pops 0-3 bytes from the head and appends 0-2 bytes at the
// tail in the same cycle. Pops larger than the fill level are clamped.
module jt900h_fetch_queue
  import jt900h_fetch_pkg::*;
#(
  parameter int QLEN = 8,
  parameter int CW   = $clog2(QLEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          clear,
  input  logic [1:0]    push_n,
  input  logic [15:0]   push_data,
  input  logic [1:0]    pop_n,
  output logic [CW-1:0] count,
  output logic [CW-1:0] nxt_count,
  output logic [31:0]   head
);

  localparam int IW = $clog2(QLEN);

  logic [QLEN-1:0][7:0] q, nq;
  logic [CW-1:0]        pop_eff, rem;
  logic [CW:0]          src;
  logic [IW-1:0]        wr1;

  // Next queue contents: shift out the clamped pop, then append at the new tail
  always_comb begin
    pop_eff   = (CW'(pop_n) > count) ? count : CW'(pop_n);
    rem       = count - pop_eff;
    nq        = '0;
    src       = '0;
    wr1       = rem[IW-1:0] + IW'(1);
    for (int i = 0; i < QLEN; i++) begin
      src = (CW+1)'(i) + {1'b0, pop_eff};
      if (src < (CW+1)'(QLEN)) nq[i] = q[src[IW-1:0]];
    end
    if (push_n != 2'd0 && rem < CW'(QLEN)) nq[rem[IW-1:0]] = push_data[7:0];
    if (push_n == 2'd2 && (rem + CW'(1)) < CW'(QLEN)) nq[wr1] = push_data[15:8];
    nxt_count = clear ? '0 : rem + CW'(push_n);
  end

  // Queue storage and fill level
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      count <= '0;
    end else if (cen) begin
      if (!clear) q <= nq;
      count <= nxt_count;
    end
  end

  // Decoder window: bytes past the fill level read as zero
  always_comb begin
    head = '0;
    for (int b = 0; b < 4; b++)
      if (CW'(b) < count) head[b*8 +: 8] = q[b];
  end

endmodule

// File: rtl/jt900h_fetch.sv
// Instruction prefetch unit: fetches 16-bit words into a byte queue and
// presents a 4-byte window to the decoder; restarts on jmp.
module jt900h_fetch
  import jt900h_fetch_pkg::*;
#(
  parameter int QLEN = 8,
  parameter int AW   = 24,
  localparam int CW  = $clog2(QLEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [1:0]    consume,
  input  logic          jmp,
  input  logic [31:0]   jmp_addr,
  output logic [31:0]   op,
  output logic [CW-1:0] avail,
  output logic [AW-1:0] bus_addr,
  output logic          bus_rd,
  input  logic          bus_ack,
  input  logic [15:0]   bus_din
);

  fstate_t       state, state_nxt;
  logic [AW-1:0] faddr, faddr_nxt, addr_nxt, faddr_even;
  logic          rd_nxt, ack, space, do_push;
  logic [1:0]    push_n;
  logic [15:0]   push_data;
  logic [CW-1:0] nxt_count;

  assign faddr_even = {faddr[AW-1:1], 1'b0};
  // An ack only counts against a live request
  assign ack        = bus_ack & bus_rd;
  assign space      = (int'(nxt_count) + FETCH_SPACE) <= QLEN;

  // Append on ack in WAIT; an odd fetch address keeps only the high byte
  assign do_push    = (state == FS_WAIT) && ack && !jmp;
  assign push_n     = do_push ? (faddr[0] ? 2'd1 : 2'd2) : 2'd0;
  assign push_data  = faddr[0] ? {8'h00, bus_din[15:8]} : bus_din;

  jt900h_fetch_queue #(.QLEN(QLEN), .CW(CW)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .clear     (jmp),
    .push_n    (push_n),
    .push_data (push_data),
    .pop_n     (jmp ? 2'd0 : consume),
    .count     (avail),
    .nxt_count (nxt_count),
    .head      (op)
  );

  // Next-state, bus request and fetch pointer
  always_comb begin
    state_nxt = state;
    rd_nxt    = bus_rd;
    addr_nxt  = bus_addr;
    faddr_nxt = faddr;
    case (state)
      FS_IDLE: begin
        if (jmp) begin
          faddr_nxt = jmp_addr[AW-1:0];
        end else if (space) begin
          state_nxt = FS_WAIT;
          rd_nxt    = 1'b1;
          addr_nxt  = faddr_even;
        end
      end
      FS_WAIT: begin
        if (jmp) begin
          faddr_nxt = jmp_addr[AW-1:0];
          // A jmp coinciding with the ack leaves nothing outstanding to drop
          if (ack) begin
            state_nxt = FS_IDLE;
            rd_nxt    = 1'b0;
          end else begin
            state_nxt = FS_DROP;
          end
        end else if (ack) begin
          state_nxt = FS_IDLE;
          rd_nxt    = 1'b0;
          faddr_nxt = faddr_even + AW'(2);
        end
      end
      FS_DROP: begin
        if (jmp) faddr_nxt = jmp_addr[AW-1:0];
        if (ack) begin
          state_nxt = FS_IDLE;
          rd_nxt    = 1'b0;
        end
      end
      default: begin
        state_nxt = FS_IDLE;
        rd_nxt    = 1'b0;
      end
    endcase
  end

  // State, bus and pointer registers; everything holds while cen is low
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FS_IDLE;
      bus_rd   <= 1'b0;
      bus_addr <= '0;
      faddr    <= '0;
    end else if (cen) begin
      state    <= state_nxt;
      bus_rd   <= rd_nxt;
      bus_addr <= addr_nxt;
      faddr    <= faddr_nxt;
    end
  end

endmodule

// File: tb/tb_jt900h_fetch.sv
// Directed bench for jt900h_fetch: fill, consume, jumps, drop, clamp, wrap, cen hold, reset.
module tb_jt900h_fetch;

  logic        clk = 1'b0;
  logic        rst, cen, jmp, bus_ack, bus_rd;
  logic [1:0]  consume;
  logic [31:0] jmp_addr, op;
  logic [3:0]  avail;
  logic [23:0] bus_addr;
  logic [15:0] bus_din;

  int errors = 0;
  int checks = 0;

  jt900h_fetch #(.QLEN(8), .AW(24)) dut (
    .clk(clk), .rst(rst), .cen(cen), .consume(consume), .jmp(jmp),
    .jmp_addr(jmp_addr), .op(op), .avail(avail), .bus_addr(bus_addr),
    .bus_rd(bus_rd), .bus_ack(bus_ack), .bus_din(bus_din)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_avail(input string name, input logic [3:0] exp);
    checks++;
    if (avail !== exp) begin
      errors++;
      $display("FAIL %s avail got=%0d exp=%0d", name, avail, exp);
    end
  endtask

  task automatic chk_op(input string name, input logic [31:0] exp);
    checks++;
    if (op !== exp) begin
      errors++;
      $display("FAIL %s op got=%h exp=%h", name, op, exp);
    end
  endtask

  task automatic chk_bus(input string name, input logic rd, input logic [23:0] a);
    checks++;
    if (bus_rd !== rd || (rd && bus_addr !== a)) begin
      errors++;
      $display("FAIL %s bus got rd=%b addr=%h exp rd=%b addr=%h", name, bus_rd, bus_addr, rd, a);
    end
  endtask

  // Wait (bounded) for a request, check its address, acknowledge with data d
  task automatic serve(input string name, input logic [15:0] d, input logic [23:0] a);
    int n = 0;
    while (bus_rd !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus_rd !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout waiting for bus_rd got=%b exp=1", name, bus_rd);
    end else if (bus_addr !== a) begin
      errors++;
      $display("FAIL %s addr got=%h exp=%h", name, bus_addr, a);
    end
    bus_ack = 1'b1;
    bus_din = d;
    tick();
    bus_ack = 1'b0;
    bus_din = 16'h0000;
  endtask

  task automatic test_reset();
    rst = 1'b1; cen = 1'b1; jmp = 1'b0; jmp_addr = '0;
    consume = 2'd0; bus_ack = 1'b0; bus_din = '0;
    tick(); tick();
    chk_avail("reset", 4'd0);
    chk_op("reset", 32'h0);
    chk_bus("reset", 1'b0, 24'h0);
    checks++;
    if (bus_addr !== 24'h0) begin
      errors++;
      $display("FAIL reset bus_addr got=%h exp=000000", bus_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    tick();
    chk_bus("fill_first", 1'b1, 24'h000000);
    serve("fill0", 16'h2211, 24'h000000); chk_avail("fill0", 4'd2);
    serve("fill1", 16'h4433, 24'h000002); chk_avail("fill1", 4'd4);
    serve("fill2", 16'h6655, 24'h000004); chk_avail("fill2", 4'd6);
    serve("fill3", 16'h8877, 24'h000006); chk_avail("fill3", 4'd8);
    tick(); tick();
    chk_bus("fill_full_idle", 1'b0, 24'h0);
    chk_op("fill", 32'h44332211);
  endtask

  task automatic test_consume_full();
    // Stray ack while nothing is outstanding must be ignored
    consume = 2'd3; bus_ack = 1'b1; bus_din = 16'hFFFF;
    tick();
    consume = 2'd0; bus_ack = 1'b0; bus_din = 16'h0;
    chk_avail("cons_full", 4'd5);
    chk_op("cons_full", 32'h77665544);
    chk_bus("cons_full_req", 1'b1, 24'h000008);
    serve("cons_refill", 16'hAA99, 24'h000008);
    chk_avail("cons_refill", 4'd7);
    tick();
    chk_bus("cons_no_req", 1'b0, 24'h0);
    chk_op("cons_refill", 32'h77665544);
  endtask

  task automatic test_jmp_idle();
    jmp = 1'b1; jmp_addr = 32'h00001235;
    tick();
    jmp = 1'b0;
    chk_avail("jmp_idle_flush", 4'd0);
    chk_bus("jmp_idle_no_req", 1'b0, 24'h0);
    serve("jmp_odd", 16'hBBAA, 24'h001234);
    chk_avail("jmp_odd", 4'd1);
    chk_op("jmp_odd", 32'h000000BB);
    tick();
    chk_bus("jmp_next", 1'b1, 24'h001236);
  endtask

  task automatic test_jmp_drop();
    jmp = 1'b1; jmp_addr = 32'h00000010;
    tick();
    jmp = 1'b0;
    chk_bus("drop_held", 1'b1, 24'h001236);
    serve("drop_a", 16'h5555, 24'h001236);
    chk_avail("drop_a", 4'd0);
    tick();
    chk_bus("drop_req10", 1'b1, 24'h000010);
    jmp = 1'b1; jmp_addr = 32'h00000100;
    tick();
    jmp = 1'b0;
    chk_bus("drop_outstanding", 1'b1, 24'h000010);
    bus_ack = 1'b1; bus_din = 16'h7777;
    tick();
    bus_ack = 1'b0;
    chk_avail("drop_b", 4'd0);
    chk_op("drop_b", 32'h0);
    serve("after_drop", 16'h2211, 24'h000100);
    chk_avail("after_drop", 4'd2);
    chk_op("after_drop", 32'h00002211);
  endtask

  task automatic test_clamp();
    consume = 2'd3;
    tick();
    consume = 2'd0;
    chk_avail("clamp", 4'd0);
    chk_op("clamp", 32'h0);
    serve("clamp_refill", 16'h4433, 24'h000102);
    chk_avail("clamp_refill", 4'd2);
    chk_op("clamp_refill", 32'h00004433);
  endtask

  task automatic test_wrap_cen();
    jmp = 1'b1; jmp_addr = 32'hAAFFFFFE;
    tick();
    jmp = 1'b0;
    serve("wrap_top", 16'hDDCC, 24'hFFFFFE);
    chk_avail("wrap_top", 4'd2);
    tick();
    chk_bus("wrap_zero", 1'b1, 24'h000000);
    cen = 1'b0; bus_ack = 1'b1; bus_din = 16'h9999; consume = 2'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_bus("cen_hold", 1'b1, 24'h000000);
      chk_avail("cen_hold", 4'd2);
      chk_op("cen_hold", 32'h0000DDCC);
    end
    cen = 1'b1; bus_ack = 1'b0; consume = 2'd0;
    serve("after_cen", 16'h2211, 24'h000000);
    chk_avail("after_cen", 4'd4);
    chk_op("after_cen", 32'h2211DDCC);
  endtask

  task automatic test_reset_mid();
    tick();
    chk_bus("mid_req", 1'b1, 24'h000002);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_bus("mid_rst_drop", 1'b0, 24'h0);
    chk_avail("mid_rst", 4'd0);
    bus_ack = 1'b1; bus_din = 16'h1111;
    tick();
    bus_ack = 1'b0;
    chk_avail("late_ack", 4'd0);
    chk_bus("late_ack_req", 1'b1, 24'h000000);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_consume_full();
    test_jmp_idle();
    test_jmp_drop();
    test_clamp();
    test_wrap_cen();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
